// File: rtl/vga_pkg.sv
// Shared types and helpers for the sprite scheduler:
// coordinate width, sprite state, FSM states, colour lookup.
package vga_pkg;

    localparam int COORD_W  = 11;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   dx;
        logic   dy;
    } sprite_t;

    typedef enum logic {
        IDLE,
        UPDATE
    } sched_state_t;

    function automatic logic [2:0] sprite_rgb(input logic [1:0] k);
        logic [2:0] c;
        unique case (k)
            2'd0: c = 3'b100;
            2'd1: c = 3'b010;
            2'd2: c = 3'b001;
            2'd3: c = 3'b111;
        endcase
        return c;
    endfunction

    // Returns {new_dir, new_pos}; bounces at 0 and lim.
    function automatic logic [COORD_W:0] axis_step(
        input coord_t p,
        input logic   d,
        input coord_t lim
    );
        logic [COORD_W:0] res;
        priority case (1'b1)
            d && (p >= lim): res = {1'b0, p - coord_t'(1)};
            !d && (p == '0): res = {1'b1, coord_t'(1)};
            d:               res = {1'b1, p + coord_t'(1)};
            default:         res = {1'b0, p - coord_t'(1)};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// Configuration write port of the sprite scheduler.
// Writes land only while cfg_ready is high.
interface sprite_scheduler_if;
    import vga_pkg::*;

    logic       cfg_we;
    logic [2:0] cfg_idx;
    coord_t     cfg_x;
    coord_t     cfg_y;
    logic       cfg_dx;
    logic       cfg_dy;
    logic       cfg_ready;

    modport master (
        output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_dx, cfg_dy,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_dx, cfg_dy,
        output cfg_ready
    );

endinterface

// File: rtl/sprite_hit.sv
// Combinational test of whether the raster pixel
// falls inside one SIZE x SIZE sprite.
module sprite_hit
    import vga_pkg::*;
#(
    parameter int SIZE = 50
) (
    input  coord_t x,
    input  coord_t y,
    input  coord_t pixelx,
    input  coord_t pixely,
    output logic   hit
);

    localparam int W = COORD_W + 1;

    logic [W-1:0] x_end;
    logic [W-1:0] y_end;

    // One extra bit so x+SIZE cannot wrap.
    assign x_end = {1'b0, x} + W'(SIZE);
    assign y_end = {1'b0, y} + W'(SIZE);

    assign hit = (pixelx >= x) && ({1'b0, pixelx} < x_end)
              && (pixely >= y) && ({1'b0, pixely} < y_end);

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame sprite motion FSM plus per-pixel priority
// arbitration driving registered r/g/b.
module sprite_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int SIZE        = 50,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        frame_start,
    input  logic [vga_pkg::COORD_W-1:0] pixelx,
    input  logic [vga_pkg::COORD_W-1:0] pixely,
    sprite_scheduler_if.slave           cfg,
    output logic                        busy,
    output logic                        update_done,
    output logic                        overrun,
    output logic                        r,
    output logic                        g,
    output logic                        b
);
    import vga_pkg::*;

    localparam coord_t X_MAX = coord_t'(H_ACTIVE - SIZE);
    localparam coord_t Y_MAX = coord_t'(V_ACTIVE - SIZE);

    sched_state_t state, state_n;
    logic [2:0] idx, idx_n;
    sprite_t spr [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;
    logic [2:0] rgb_n;
    logic cfg_wr;

    assign cfg.cfg_ready = (state == IDLE) && rst;
    assign cfg_wr = cfg.cfg_we && cfg.cfg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        busy        = 1'b0;
        update_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start && enable) begin
                    state_n = UPDATE;
                    idx_n   = '0;
                end
            end
            UPDATE: begin
                busy  = 1'b1;
                idx_n = idx + 3'd1;
                if (idx == 3'(NUM_SPRITES - 1)) begin
                    update_done = 1'b1;
                    state_n     = IDLE;
                    idx_n       = '0;
                end
            end
        endcase
    end

    // Writes only land in IDLE, so they never race an update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr[i] <= '{x:  coord_t'(50 + 100 * i),
                            y:  coord_t'(50 + 60 * i),
                            dx: (i % 2 == 0),
                            dy: (i % 2 == 0)};
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (state == UPDATE && idx == 3'(i)) begin
                    {spr[i].dx, spr[i].x} <= axis_step(spr[i].x, spr[i].dx, X_MAX);
                    {spr[i].dy, spr[i].y} <= axis_step(spr[i].y, spr[i].dy, Y_MAX);
                end else if (cfg_wr && cfg.cfg_idx == 3'(i)) begin
                    spr[i].x  <= (cfg.cfg_x > X_MAX) ? X_MAX : cfg.cfg_x;
                    spr[i].y  <= (cfg.cfg_y > Y_MAX) ? Y_MAX : cfg.cfg_y;
                    spr[i].dx <= cfg.cfg_dx;
                    spr[i].dy <= cfg.cfg_dy;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (frame_start && state == UPDATE) begin
            overrun <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
        sprite_hit #(.SIZE(SIZE)) u_hit (
            .x      (spr[gi].x),
            .y      (spr[gi].y),
            .pixelx (pixelx),
            .pixely (pixely),
            .hit    (hit[gi])
        );
    end

    // Scan high to low so the lowest hit index wins.
    always_comb begin
        rgb_n = 3'b000;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                rgb_n = sprite_rgb(2'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r, g, b} <= 3'b000;
        end else begin
            {r, g, b} <= rgb_n;
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: directed scenarios plus random
// traffic checked every cycle against a behavioural model.
module tb_sprite_scheduler;

    localparam int N  = 4;
    localparam int SZ = 50;
    localparam int HA = 640;
    localparam int VA = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        frame_start = 1'b0;
    logic [10:0] pixelx = '0;
    logic [10:0] pixely = '0;
    logic        busy, update_done, overrun, r, g, b;

    sprite_scheduler_if cfg_bus ();

    sprite_scheduler #(
        .NUM_SPRITES (N),
        .SIZE        (SZ),
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .pixelx      (pixelx),
        .pixely      (pixely),
        .cfg         (cfg_bus),
        .busy        (busy),
        .update_done (update_done),
        .overrun     (overrun),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: sprite positions and pass bookkeeping.
    int mx [N];
    int my [N];
    int mdx [N];
    int mdy [N];
    bit mpass;
    bit movr;
    int cyc;
    int tstart;
    logic [2:0] e_rgb;

    function automatic logic [2:0] colour_of(input int i);
        case (i % 4)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] model_pixel(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            if (px >= mx[i] && px < mx[i] + SZ && py >= my[i] && py < my[i] + SZ)
                return colour_of(i);
        end
        return 3'b000;
    endfunction

    task automatic mv(input int p, input int d, input int lim,
                      output int np, output int nd);
        if (d == 1) begin
            if (p >= lim) begin nd = 0; np = p - 1; end
            else begin nd = 1; np = p + 1; end
        end else begin
            if (p == 0) begin nd = 1; np = 1; end
            else begin nd = 0; np = p - 1; end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]  = 50 + 100 * i;
            my[i]  = 50 + 60 * i;
            mdx[i] = (i % 2 == 0) ? 1 : 0;
            mdy[i] = mdx[i];
        end
        mpass = 0;
        movr  = 0;
        e_rgb = 3'b000;
    endtask

    always @(posedge clk or negedge rst) begin : mdl
        int k, np, nd, ci;
        if (!rst) begin
            model_reset();
        end else begin
            cyc++;
            e_rgb = model_pixel(int'(pixelx), int'(pixely));
            if (mpass && cyc - tstart >= 1 && cyc - tstart <= N) begin
                k = cyc - tstart - 1;
                mv(mx[k], mdx[k], HA - SZ, np, nd);
                mx[k] = np; mdx[k] = nd;
                mv(my[k], mdy[k], VA - SZ, np, nd);
                my[k] = np; mdy[k] = nd;
                if (frame_start) movr = 1;
                if (k == N - 1) mpass = 0;
            end else begin
                ci = int'(cfg_bus.cfg_idx);
                if (cfg_bus.cfg_we && ci < N) begin
                    mx[ci]  = (int'(cfg_bus.cfg_x) > HA - SZ) ? HA - SZ : int'(cfg_bus.cfg_x);
                    my[ci]  = (int'(cfg_bus.cfg_y) > VA - SZ) ? VA - SZ : int'(cfg_bus.cfg_y);
                    mdx[ci] = int'(cfg_bus.cfg_dx);
                    mdy[ci] = int'(cfg_bus.cfg_dy);
                end
                if (frame_start && enable) begin
                    mpass  = 1;
                    tstart = cyc;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("rgb", int'({r, g, b}), int'(e_rgb));
        chk("busy", int'(busy), int'(mpass));
        chk("update_done", int'(update_done), (mpass && cyc - tstart == N - 1) ? 1 : 0);
        chk("overrun", int'(overrun), int'(movr));
        chk("cfg_ready", int'(cfg_bus.cfg_ready), (!mpass && rst) ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("x[%0d]", i), int'(dut.spr[i].x), mx[i]);
            chk($sformatf("y[%0d]", i), int'(dut.spr[i].y), my[i]);
            chk($sformatf("dx[%0d]", i), int'(dut.spr[i].dx), mdx[i]);
            chk($sformatf("dy[%0d]", i), int'(dut.spr[i].dy), mdy[i]);
        end
    end

    task automatic cfg_write(input int idx, input int x, input int y,
                             input int dx, input int dy);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_idx = 3'(idx);
        cfg_bus.cfg_x   = 11'(x);
        cfg_bus.cfg_y   = 11'(y);
        cfg_bus.cfg_dx  = 1'(dx);
        cfg_bus.cfg_dy  = 1'(dy);
        @(negedge clk);
        cfg_bus.cfg_we  = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (N + 2) @(negedge clk);
    endtask

    initial begin : stim
        int nb, nd, j, px;
        cfg_bus.cfg_we  = 1'b0;
        cfg_bus.cfg_idx = '0;
        cfg_bus.cfg_x   = '0;
        cfg_bus.cfg_y   = '0;
        cfg_bus.cfg_dx  = 1'b0;
        cfg_bus.cfg_dy  = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset cfg_ready", int'(cfg_bus.cfg_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset rgb", int'({r, g, b}), 0);
        chk("reset s0 x", int'(dut.spr[0].x), 50);
        chk("reset s0 y", int'(dut.spr[0].y), 50);
        chk("reset s1 x", int'(dut.spr[1].x), 150);
        chk("reset s1 y", int'(dut.spr[1].y), 110);
        pixelx = 11'd60; pixely = 11'd60;
        @(negedge clk);
        chk("pixel 60,60 rgb", int'({r, g, b}), 3'b100);
        pixelx = '0; pixely = '0;

        // Single frame: busy and done timing.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) nb++;
            if (update_done) begin
                nd++;
                chk("done in last busy cycle", nb, 4);
            end
            @(negedge clk);
        end
        chk("busy cycles", nb, 4);
        chk("done pulses", nd, 1);
        chk("frame s0 x", int'(dut.spr[0].x), 51);
        chk("frame s0 y", int'(dut.spr[0].y), 51);
        chk("frame s1 x", int'(dut.spr[1].x), 149);
        chk("frame s1 y", int'(dut.spr[1].y), 109);

        // Edge bounce with clamped write.
        cfg_write(0, 700, 0, 1, 0);
        chk("clamp s0 x", int'(dut.spr[0].x), 590);
        chk("clamp s0 y", int'(dut.spr[0].y), 0);
        pulse_frame();
        chk("bounce s0 x", int'(dut.spr[0].x), 589);
        chk("bounce s0 dx", int'(dut.spr[0].dx), 0);
        chk("bounce s0 y", int'(dut.spr[0].y), 1);
        chk("bounce s0 dy", int'(dut.spr[0].dy), 1);

        // Priority between overlapping sprites.
        cfg_write(0, 200, 200, 1, 1);
        cfg_write(2, 200, 200, 1, 1);
        pixelx = 11'd210; pixely = 11'd210;
        @(negedge clk);
        chk("overlap rgb", int'({r, g, b}), 3'b100);
        cfg_write(0, 400, 0, 1, 1);
        @(negedge clk);
        chk("s2 alone rgb", int'({r, g, b}), 3'b001);

        // Dropped write and overrun during a pass.
        frame_start = 1'b1;
        @(negedge clk);
        chk("busy cfg_ready", int'(cfg_bus.cfg_ready), 0);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_idx = 3'd1;
        cfg_bus.cfg_x   = 11'd10;
        cfg_bus.cfg_y   = 11'd10;
        @(negedge clk);
        cfg_bus.cfg_we = 1'b0;
        frame_start    = 1'b0;
        chk("overrun set", int'(overrun), 1);
        repeat (N) @(negedge clk);
        chk("dropped write s1 x", int'(dut.spr[1].x), 147);
        chk("dropped write s1 y", int'(dut.spr[1].y), 107);
        pulse_frame();
        chk("overrun sticky", int'(overrun), 1);

        // Reset during the second update cycle.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset busy", int'(busy), 0);
        chk("midreset overrun", int'(overrun), 0);
        chk("midreset s0 x", int'(dut.spr[0].x), 50);
        chk("midreset s0 y", int'(dut.spr[0].y), 50);
        chk("midreset s1 x", int'(dut.spr[1].x), 150);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (update_done) nd++;
        end
        chk("midreset no done", nd, 0);
        rst = 1'b1;
        @(negedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            frame_start     = ($urandom_range(0, 9) == 0);
            enable          = ($urandom_range(0, 9) != 0);
            cfg_bus.cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_bus.cfg_idx = 3'($urandom_range(0, 7));
            cfg_bus.cfg_x   = 11'($urandom_range(0, 800));
            cfg_bus.cfg_y   = 11'($urandom_range(0, 600));
            cfg_bus.cfg_dx  = 1'($urandom_range(0, 1));
            cfg_bus.cfg_dy  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                j  = $urandom_range(0, N - 1);
                px = mx[j] + $urandom_range(0, 60) - 5;
                pixelx = 11'((px < 0) ? 0 : px);
                px = my[j] + $urandom_range(0, 60) - 5;
                pixely = 11'((px < 0) ? 0 : px);
            end else begin
                pixelx = 11'($urandom_range(0, 700));
                pixely = 11'($urandom_range(0, 520));
            end
            @(negedge clk);
        end
        frame_start    = 1'b0;
        cfg_bus.cfg_we = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Per-frame motion scheduler and pixel arbiter for NUM_SPRITES square sprites on the 640x480 VGA raster. The block sits between the VGA timing generator and the RGB output pins. On each frame_start pulse during blanking it runs a one-sprite-per-cycle state machine that advances every sprite by one pixel and bounces it off the screen edges. During active video it arbitrates the overlapping sprites for each pixel and drives registered r/g/b.

## Interface
- NUM_SPRITES, default 4: number of sprites; legal range 1..8.
- SIZE, default 50: sprite width and height in pixels.
- H_ACTIVE, default 640: visible width.
- V_ACTIVE, default 480: visible height.
- clk  in  1  pixel clock (25 MHz); single clock domain.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst=0.
- enable  in  1  when 0, frame_start is ignored and sprites freeze.
- frame_start  in  1  one-cycle pulse from the timing generator at the start of vertical blank.
- pixelx, pixely  in  11 each  current raster coordinate.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  3  target sprite for the write.
- cfg_x, cfg_y  in  11 each  new position of the sprite's top-left corner.
- cfg_dx, cfg_dy  in  1 each  new direction; 1 = increasing, 0 = decreasing.
- cfg_ready  out  1  high when a configuration write will be accepted.
- busy  out  1  high while the UPDATE state is active.
- update_done  out  1  one-cycle pulse after the last sprite has been updated.
- overrun  out  1  sticky; set when frame_start arrives while busy. Cleared only by reset.
- r, g, b  out  1 each  registered pixel colour.

## Operation
- Per-sprite state: x and y (11 bits each), dx and dy (1 bit each). Reset values:
  - x = 50 + 100*i
  - y = 50 + 60*i
  - dx = dy = (i even)
- FSM states: IDLE and UPDATE. Reset state is IDLE.
- IDLE -> UPDATE when frame_start=1 and enable=1. The sprite index idx is cleared to 0.
- In UPDATE, one sprite is processed per cycle (sprite idx). idx increments each cycle. After idx = NUM_SPRITES-1 the FSM returns to IDLE and update_done pulses for that cycle.
- Axis update rule (x shown; y is identical with V_ACTIVE):
  - If dx=1 and x >= H_ACTIVE-SIZE: dx <= 0 and x <= x-1.
  - Else if dx=0 and x == 0: dx <= 1 and x <= 1.
  - Else x <= x+1 when dx=1, or x <= x-1 when dx=0.
  - No wrap-around; a sprite never leaves the range [0, H_ACTIVE-SIZE].
- Configuration writes:
  - cfg_ready = (state == IDLE) and rst=1.
  - A write is accepted when cfg_we=1 and cfg_ready=1. cfg_we while not ready is dropped silently.
  - cfg_x is clamped to H_ACTIVE-SIZE and cfg_y to V_ACTIVE-SIZE.
  - cfg_idx >= NUM_SPRITES is ignored.
  - If cfg_we and frame_start are both high in IDLE in the same cycle, the write commits first and the UPDATE pass operates on the written values.
- frame_start while in UPDATE: ignored, and overrun is set.
- Pixel arbitration:
  - hit_i = (x_i <= pixelx < x_i+SIZE) and (y_i <= pixely < y_i+SIZE).
  - The lowest hit index wins.
  - Colour is chosen by (index mod 4): 0 = red (100), 1 = green (010), 2 = blue (001), 3 = white (111).
  - No hit gives 000.
  - Arbitration uses the live position registers. Updates only occur during blanking, so no shadow copy is required.
- Reset mid-UPDATE: all state returns immediately to the reset values. The partial pass is discarded.

## Timing
- Output values during reset: r=g=b=0, busy=0, update_done=0, overrun=0, cfg_ready=0.
- If frame_start is sampled at edge T, busy is high over cycles T+1 .. T+NUM_SPRITES.
- Sprite i is updated at edge T+1+i.
- update_done is high in cycle T+NUM_SPRITES.
- cfg_ready returns high in cycle T+NUM_SPRITES+1.
- Pixel path latency is 1 cycle: r/g/b reflect the pixelx/pixely presented at the previous edge.
- Maximum pass length is 8 cycles, which is far shorter than the 45-line vertical blank.

## Structure
- vga_pkg holds:
  - COORD_W = 11, H_ACTIVE, V_ACTIVE.
  - sprite_t struct {x, y, dx, dy}.
  - sched_state_t enum {IDLE, UPDATE}.
  - the colour lookup function.
- One sub-module, sprite_hit: purely combinational rectangle compare (x, y, pixelx, pixely, SIZE -> hit). It is instantiated NUM_SPRITES times via generate.
- The priority encoder, FSM and output register live in sprite_scheduler.

## Test plan
- Reset state: release rst -> sprite0 at (50,50), sprite1 at (150,110); cfg_ready=1, busy=0, rgb=000. Pixel (60,60) gives rgb=100 one cycle later.
- Single frame: pulse frame_start -> busy high for exactly 4 cycles, update_done pulses in the 4th. Afterwards sprite0 is at (51,51) and sprite1 is at (149,109).
- Edge bounce: write sprite0 x=700, y=0, dx=1, dy=0 -> x is clamped to 590. After the next frame: x=589, dx=0, y=1, dy=1.
- Priority: place sprite0 and sprite2 both at (200,200) -> pixel (210,210) gives 100. Move sprite0 away -> the same pixel gives 001.
- Handshake and overrun: cfg_we during busy is dropped and the position is unchanged. A second frame_start during busy sets overrun, which stays set through later frames.
- Reset mid-pass: assert rst at the 2nd UPDATE cycle -> all positions return to their reset values, busy=0, no update_done pulse.
